// File: rtl/adpll_pkg.sv
// Shared types and constants for the 5-bit ADPLL lock detector.
package adpll_pkg;

   localparam int ERR_W       = 5;
   localparam int CNT_W       = 4;
   localparam int ERR_MAX_DEF = 31;

   typedef enum logic [1:0] {
      M_IDLE     = 2'd0,
      M_WAIT_FB  = 2'd1,
      M_WAIT_REF = 2'd2
   } meas_state_e;

   typedef enum logic [1:0] {
      L_UNLOCKED = 2'd0,
      L_ACQUIRE  = 2'd1,
      L_LOCKED   = 2'd2,
      L_HOLD     = 2'd3
   } lock_state_e;

   // A programmed count of zero behaves as one.
   function automatic logic [CNT_W-1:0] eff_count(input logic [CNT_W-1:0] c);
      logic [CNT_W-1:0] r;
      if (c == 4'd0) begin
         r = 4'd1;
      end else begin
         r = c;
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_sync_det.sv
// Multi-flop synchronizer followed by a rising-edge pulse generator.
module edge_sync_det #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic d_i,
   output logic rise_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   prev_q;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
         prev_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/adpll_lock_detect_5bit.sv
// ADPLL lock detector: measures ref/fb rising-edge separation and runs a hysteretic lock FSM.
// Define ADPLL_LOCK_SLIP_CNT_EN to enable slip counting and forced unlock on slip.
module adpll_lock_detect_5bit #(
   parameter int SYNC_STAGES = 2,
   parameter int ERR_MAX     = adpll_pkg::ERR_MAX_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clk_ref,
   input  logic                        fb_clk,
   input  logic [adpll_pkg::ERR_W-1:0] lock_thresh,
   input  logic [adpll_pkg::CNT_W-1:0] lock_count,
   input  logic [adpll_pkg::CNT_W-1:0] unlock_count,
   output logic [adpll_pkg::ERR_W-1:0] phase_err,
   output logic                        err_sign,
   output logic                        err_valid,
   output logic                        locked,
   output logic [adpll_pkg::CNT_W-1:0] slip_cnt
);
   import adpll_pkg::*;

   localparam logic [ERR_W-1:0] ERR_MAX_C = ERR_W'(ERR_MAX);

   logic ref_rise_s;
   logic fb_rise_s;

   edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_ref_det (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (clk_ref),
      .rise_o(ref_rise_s)
   );

   edge_sync_det #(.SYNC_STAGES(SYNC_STAGES)) u_fb_det (
      .clk_i (clk),
      .rst_i (reset),
      .d_i   (fb_clk),
      .rise_o(fb_rise_s)
   );

   meas_state_e      meas_q, meas_d;
   logic [ERR_W-1:0] cnt_q, cnt_d;
   logic [ERR_W-1:0] cnt_inc_s;
   logic             lead_fb_s;
   logic             opp_s;
   logic             same_s;
   logic             pub_s;
   logic [ERR_W-1:0] pub_err_s;
   logic             pub_sign_s;

   logic [ERR_W-1:0] phase_err_q;
   logic             err_sign_q;
   logic             err_valid_q;

   // In WAIT_REF the feedback edge came first, so "opposite" is the reference edge.
   assign lead_fb_s = (meas_q == M_WAIT_REF);
   assign opp_s     = lead_fb_s ? ref_rise_s : fb_rise_s;
   assign same_s    = lead_fb_s ? fb_rise_s  : ref_rise_s;
   assign cnt_inc_s = (cnt_q >= ERR_MAX_C) ? ERR_MAX_C : (cnt_q + 5'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meas_q <= M_IDLE;
         cnt_q  <= 5'd0;
      end else begin
         meas_q <= meas_d;
         cnt_q  <= cnt_d;
      end
   end

   always_comb begin
      meas_d = meas_q;
      cnt_d  = cnt_q;
      case (meas_q)
         M_IDLE: begin
            if (ref_rise_s && fb_rise_s) begin
               meas_d = M_IDLE;
               cnt_d  = 5'd0;
            end else if (ref_rise_s) begin
               meas_d = M_WAIT_FB;
               cnt_d  = 5'd1;
            end else if (fb_rise_s) begin
               meas_d = M_WAIT_REF;
               cnt_d  = 5'd1;
            end else begin
               meas_d = M_IDLE;
               cnt_d  = 5'd0;
            end
         end
         M_WAIT_FB, M_WAIT_REF: begin
            if (opp_s && same_s) begin
               meas_d = meas_q;
               cnt_d  = 5'd1;
            end else if (opp_s) begin
               meas_d = M_IDLE;
               cnt_d  = 5'd0;
            end else if (same_s) begin
               meas_d = meas_q;
               cnt_d  = 5'd1;
            end else begin
               meas_d = meas_q;
               cnt_d  = cnt_inc_s;
            end
         end
         default: begin
            meas_d = M_IDLE;
            cnt_d  = 5'd0;
         end
      endcase
   end

   always_comb begin
      pub_s      = 1'b0;
      pub_err_s  = 5'd0;
      pub_sign_s = 1'b0;
      case (meas_q)
         M_IDLE: begin
            if (ref_rise_s && fb_rise_s) begin
               pub_s = 1'b1;
            end else begin
               pub_s = 1'b0;
            end
         end
         M_WAIT_FB, M_WAIT_REF: begin
            if (opp_s) begin
               pub_s      = 1'b1;
               pub_err_s  = cnt_q;
               pub_sign_s = lead_fb_s;
            end else if (same_s) begin
               pub_s      = 1'b1;
               pub_err_s  = ERR_MAX_C;
               pub_sign_s = lead_fb_s;
            end else begin
               pub_s = 1'b0;
            end
         end
         default: begin
            pub_s = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         phase_err_q <= 5'd0;
         err_sign_q  <= 1'b0;
         err_valid_q <= 1'b0;
      end else begin
         err_valid_q <= pub_s;
         if (pub_s) begin
            phase_err_q <= pub_err_s;
            err_sign_q  <= pub_sign_s;
         end
      end
   end

   lock_state_e      lock_q, lock_d;
   logic [CNT_W-1:0] run_q, run_d;
   logic [CNT_W-1:0] miss_q, miss_d;
   logic             locked_q, locked_d;
   logic             good_s;
   logic             slip_force_s;
   logic [CNT_W-1:0] lc_eff_s;
   logic [CNT_W-1:0] uc_eff_s;

   assign good_s   = (phase_err_q <= lock_thresh);
   assign lc_eff_s = eff_count(lock_count);
   assign uc_eff_s = eff_count(unlock_count);

`ifdef ADPLL_LOCK_SLIP_CNT_EN
   logic             slip_s;
   logic             slip_q;
   logic [CNT_W-1:0] slip_cnt_q;

   assign slip_s = (meas_q != M_IDLE) && same_s && !opp_s;

   // Slip flag travels alongside err_valid; the counter saturates at 15.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slip_q     <= 1'b0;
         slip_cnt_q <= 4'd0;
      end else begin
         slip_q <= slip_s;
         if (slip_s && (slip_cnt_q != 4'd15)) begin
            slip_cnt_q <= slip_cnt_q + 4'd1;
         end
      end
   end

   assign slip_force_s = slip_q && ((lock_q == L_LOCKED) || (lock_q == L_HOLD));
   assign slip_cnt     = slip_cnt_q;
`else
   assign slip_force_s = 1'b0;
   assign slip_cnt     = 4'd0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lock_q   <= L_UNLOCKED;
         run_q    <= 4'd0;
         miss_q   <= 4'd0;
         locked_q <= 1'b0;
      end else begin
         lock_q   <= lock_d;
         run_q    <= run_d;
         miss_q   <= miss_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      lock_d = lock_q;
      run_d  = run_q;
      miss_d = miss_q;
      if (!err_valid_q) begin
         lock_d = lock_q;
      end else if (slip_force_s) begin
         lock_d = L_UNLOCKED;
         run_d  = 4'd0;
         miss_d = 4'd0;
      end else begin
         case (lock_q)
            L_UNLOCKED: begin
               if (good_s) begin
                  lock_d = (lc_eff_s == 4'd1) ? L_LOCKED : L_ACQUIRE;
                  run_d  = 4'd1;
               end else begin
                  run_d  = 4'd0;
               end
            end
            L_ACQUIRE: begin
               if (good_s) begin
                  run_d  = run_q + 4'd1;
                  lock_d = ((run_q + 4'd1) >= lc_eff_s) ? L_LOCKED : L_ACQUIRE;
               end else begin
                  lock_d = L_UNLOCKED;
                  run_d  = 4'd0;
               end
            end
            L_LOCKED: begin
               if (good_s) begin
                  miss_d = 4'd0;
               end else begin
                  lock_d = (uc_eff_s == 4'd1) ? L_UNLOCKED : L_HOLD;
                  miss_d = 4'd1;
                  run_d  = 4'd0;
               end
            end
            L_HOLD: begin
               if (good_s) begin
                  lock_d = L_LOCKED;
                  miss_d = 4'd0;
               end else begin
                  miss_d = miss_q + 4'd1;
                  lock_d = ((miss_q + 4'd1) >= uc_eff_s) ? L_UNLOCKED : L_HOLD;
               end
            end
            default: begin
               lock_d = L_UNLOCKED;
               run_d  = 4'd0;
               miss_d = 4'd0;
            end
         endcase
      end
   end

   always_comb begin
      locked_d = (lock_d == L_LOCKED) || (lock_d == L_HOLD);
   end

   assign phase_err = phase_err_q;
   assign err_sign  = err_sign_q;
   assign err_valid = err_valid_q;
   assign locked    = locked_q;

endmodule
